// File: rtl/mips_pkg.sv
// Shared constants for the MIPS data-memory preload path: default widths
// and the loader FSM state encoding.
package mips_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

endpackage

// File: rtl/dmem_loader_ctr.sv
// Loadable up-counter with a terminal-count flag. Used as the write index
// and the read index of the preload engine.
module dmem_loader_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load takes priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/dmem_loader.sv
// Data-memory preload engine: streams words into consecutive addresses,
// reads the window back, compares sums, and releases the CPU on success.
//
// state  | meaning
// IDLE   | waiting for start, CPU held
// LOAD   | accepting stream words, one registered write per handshake
// VERIFY | reading the window back and summing read data
// DONE   | image verified, CPU released
// ERROR  | range or checksum failure, CPU held
module dmem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W+1:0] MEM_SIZE = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_prev_q, re_prev_d;

  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic              wr_tc, rd_tc;
  logic              idx_load;
  logic              hs;
  logic [ADDR_W+1:0] end_addr;
  logic              range_bad;
  logic [DATA_W-1:0] rsum_sum;
  logic              unused_msb;

  // Widened so base+count cannot wrap before the range compare.
  assign end_addr  = {2'b00, base_addr} + {1'b0, word_count};
  assign range_bad = (end_addr > MEM_SIZE) || (word_count > MAX_CNT);

  assign in_ready  = (state_q == ST_LOAD) && !wr_tc;
  assign hs        = in_valid && in_ready;
  assign mem_re    = (state_q == ST_VERIFY) && !rd_tc;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = mem_re ? (base_q + rd_cnt[ADDR_W-1:0]) : waddr_q;
  assign rsum_sum  = rsum_q + mem_rdata;
  assign cpu_hold  = (state_q != ST_DONE);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign checksum  = checksum_q;

  // Index MSBs only matter for the terminal-count compare inside the counters.
  assign unused_msb = wr_cnt[ADDR_W] ^ rd_cnt[ADDR_W];

  dmem_loader_ctr #(.W(CNT_W)) u_wr_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load),
    .load_val ('0),
    .inc      (hs),
    .term     (count_q),
    .cnt      (wr_cnt),
    .tc       (wr_tc)
  );

  dmem_loader_ctr #(.W(CNT_W)) u_rd_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load),
    .load_val ('0),
    .inc      (mem_re),
    .term     (count_q),
    .cnt      (rd_cnt),
    .tc       (rd_tc)
  );

  // FSM next state, write staging and checksum accumulation.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    rsum_d     = rsum_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_prev_d  = mem_re;
    idx_load   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          checksum_d = '0;
          rsum_d     = '0;
          idx_load   = 1'b1;
          if (range_bad) begin
            state_d = ST_ERROR;
          end else if (word_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
          we_d       = 1'b1;
          waddr_d    = base_q + wr_cnt[ADDR_W-1:0];
          wdata_d    = in_data;
          checksum_d = checksum_q + in_data;
        end
        // Leave only after the final registered write has been presented.
        if (we_q && wr_tc) begin
          state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (re_prev_q) begin
          rsum_d = rsum_sum;
        end
        // Extra cycle after the last read collects its data before deciding.
        if (rd_tc) begin
          state_d = (rsum_sum == checksum_q) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      rsum_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      re_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      rsum_q     <= rsum_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      re_prev_q  <= re_prev_d;
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Bench for dmem_loader: directed loads with a scoreboard of expected
// memory writes and reads, checked by an independent monitor.
module tb_dmem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  logic [31:0] mem [0:255];
  logic        corrupt;
  logic [31:0] img [0:4];
  logic [39:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  int          n_cmp;
  int          n_bad;

  dmem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory model: write on edge, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (corrupt && mem_addr == 8'd12) ? 32'd7 : mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT drives memory traffic.
  initial begin
    logic [39:0] ew;
    logic [7:0]  er;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_we && mem_re) check("we_re_exclusive", 1, 0);
        if (mem_we) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_write", {mem_addr, mem_wdata}, 0);
            if ({mem_addr, mem_wdata} == 0) check("unexpected_write_flag", 1, 0);
          end else begin
            ew = exp_wr.pop_front();
            check("write", {mem_addr, mem_wdata}, ew);
          end
        end
        if (mem_re) begin
          if (exp_rd.size() == 0) begin
            check("unexpected_read", 1, 0);
          end else begin
            er = exp_rd.pop_front();
            check("read_addr", mem_addr, er);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w);
    int t;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("handshake_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_status(output int lat);
    int t;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) check("status_timeout", {done, error}, 2'b10);
    lat = t;
  endtask

  // Called at a negedge; loads img[0..4] at base, optional stall before word gap_after.
  task automatic run_load(input int base, input int gap_after, input int gap_len, output int lat);
    for (int i = 0; i < 5; i++) exp_wr.push_back({8'(base + i), img[i]});
    for (int i = 0; i < 5; i++) exp_rd.push_back(8'(base + i));
    start      = 1'b1;
    base_addr  = 8'(base);
    word_count = 9'd5;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("hold_after_start", cpu_hold, 1);
    check("done_cleared", done, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == gap_after) begin
        for (int k = 0; k < gap_len; k++) begin
          check("gap_in_ready", in_ready, 1);
          if (k > 0) check("gap_no_we", mem_we, 0);
          @(negedge clk);
        end
      end
      send_word(img[i]);
    end
    wait_status(lat);
  endtask

  task automatic check_mem(input int base);
    for (int i = 0; i < 5; i++) check("mem_contents", mem[8'(base + i)], img[i]);
  endtask

  task automatic check_queues();
    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hdead_0000 + i;
    img[0] = 32'd2; img[1] = 32'd0; img[2] = 32'd2; img[3] = 32'd1; img[4] = 32'd0;
    corrupt    = 1'b0;
    mem_rdata  = '0;
    reset      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;

    // Reset values
    @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_checksum", checksum, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic load and release
    run_load(10, -1, 0, lat);
    check("basic_done", done, 1);
    check("basic_error", error, 0);
    check("basic_cpu_hold", cpu_hold, 0);
    check("basic_busy", busy, 0);
    check("basic_checksum", checksum, 5);
    check("basic_release_latency_le12", lat <= 12, 1);
    check_mem(10);
    check_queues();

    // Stalled stream
    run_load(40, 2, 3, lat);
    check("stall_done", done, 1);
    check("stall_checksum", checksum, 5);
    check("stall_cpu_hold", cpu_hold, 0);
    check_mem(40);
    check_queues();

    // Range error
    start = 1'b1; base_addr = 8'd250; word_count = 9'd10;
    @(negedge clk);
    start = 1'b0;
    check("range_error", error, 1);
    check("range_done", done, 0);
    check("range_cpu_hold", cpu_hold, 1);
    check("range_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("range_error_held", error, 1);
    check_queues();

    // Zero count
    start = 1'b1; base_addr = 8'd20; word_count = 9'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_error", error, 0);
    check("zero_checksum", checksum, 0);
    check("zero_cpu_hold", cpu_hold, 0);
    repeat (3) @(negedge clk);
    check_queues();

    // Verify mismatch, then clean restart
    corrupt = 1'b1;
    run_load(10, -1, 0, lat);
    check("mismatch_error", error, 1);
    check("mismatch_done", done, 0);
    check("mismatch_cpu_hold", cpu_hold, 1);
    check("mismatch_checksum", checksum, 5);
    check_queues();
    corrupt = 1'b0;
    run_load(10, -1, 0, lat);
    check("restart_done", done, 1);
    check("restart_error", error, 0);
    check("restart_cpu_hold", cpu_hold, 0);
    check_queues();

    // Reset mid-LOAD after two words
    exp_wr.push_back({8'd60, img[0]});
    exp_wr.push_back({8'd61, img[1]});
    start = 1'b1; base_addr = 8'd60; word_count = 9'd5;
    @(negedge clk);
    start = 1'b0;
    send_word(img[0]);
    send_word(img[1]);
    #1;
    reset = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_cpu_hold", cpu_hold, 1);
    check("abort_mem_we", mem_we, 0);
    check("abort_checksum", checksum, 0);
    check("abort_done_error", {done, error}, 0);
    @(negedge clk);
    reset = 1'b1;
    check_queues();
    @(negedge clk);
    run_load(60, -1, 0, lat);
    check("after_abort_done", done, 1);
    check("after_abort_checksum", checksum, 5);
    check_mem(60);
    check_queues();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
